// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard controller and its mult/div timer.
package hazard_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int MD_CNT_W = 8;

endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// Mult/div occupancy timer: counts down MD_LATENCY busy cycles from each accepted start.
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic accept,
    output logic md_busy,
    output logic md_done
);

    localparam logic [MD_CNT_W-1:0] LOAD_VAL = MD_CNT_W'(MD_LATENCY);
    localparam logic [MD_CNT_W-1:0] ONE      = MD_CNT_W'(1);

    md_state_t state;
    logic [MD_CNT_W-1:0] md_cnt;

    // Starts are only honoured from idle; the controller's stall logic keeps them out while busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= MD_IDLE;
            md_cnt <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (accept) begin
                        state  <= MD_BUSY;
                        md_cnt <= LOAD_VAL;
                    end
                end
                MD_BUSY: begin
                    md_cnt <= md_cnt - ONE;
                    if (md_cnt == ONE) begin
                        state <= MD_IDLE;
                    end
                end
                default: begin
                    state  <= MD_IDLE;
                    md_cnt <= '0;
                end
            endcase
        end
    end

    assign md_busy = rst_n & (md_cnt != '0);
    assign md_done = rst_n & (md_cnt == ONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and mult/div stalls, taken-branch flushes,
// and a saturating count of stall cycles.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_md_start,
    input  logic             id_md_use,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_wr_reg,
    input  logic             ex_branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt
);

    logic load_use;
    logic md_stall;
    logic stall;
    logic accept;

    assign load_use = ex_mem_read & (ex_wr_reg != REG_ZERO) &
                      ((id_use_rs & (id_rs == ex_wr_reg)) |
                       (id_use_rt & (id_rt == ex_wr_reg)));
    assign md_stall = md_busy & (id_md_start | id_md_use);
    assign stall    = md_stall | load_use;

    // A flushed ID instruction is discarded, so it must not launch a mult/div.
    assign accept   = rst_n & id_md_start & ~stall & ~ex_branch_taken;

    md_busy_timer #(
        .MD_LATENCY(MD_LATENCY)
    ) u_md_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (accept),
        .md_busy(md_busy),
        .md_done(md_done)
    );

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!rst_n) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (stall) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && !ex_branch_taken && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic checked
// against a cycle-indexed reference model.
module tb_hazard_ctrl;

    localparam int L     = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       md_start;
        logic       md_use;
        logic       mem_read;
        logic [4:0] wr;
        logic       br;
    } stim_t;

    typedef struct packed {
        logic [5:0]       ctl;
        logic [CNT_W-1:0] cnt;
        int               cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    stim_t cur;
    stim_t s;
    localparam stim_t IDLE = '{rst_n: 1'b1, default: '0};

    logic pc_en, ifid_en, ifid_flush, idex_flush, md_busy, md_done;
    logic [CNT_W-1:0] stall_cnt;

    hazard_ctrl #(
        .MD_LATENCY(L),
        .CNT_W     (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (cur.rst_n),
        .id_rs          (cur.rs),
        .id_rt          (cur.rt),
        .id_use_rs      (cur.use_rs),
        .id_use_rt      (cur.use_rt),
        .id_md_start    (cur.md_start),
        .id_md_use      (cur.md_use),
        .ex_mem_read    (cur.mem_read),
        .ex_wr_reg      (cur.wr),
        .ex_branch_taken(cur.br),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .md_busy        (md_busy),
        .md_done        (md_done),
        .stall_cnt      (stall_cnt)
    );

    // Reference model: the mult/div is busy in the L cycles starting at the cycle
    // right after its accepting edge; stall count is a saturating integer.
    int   cyc = 0;
    int   acc_cyc = -1000;
    int   scnt = 0;
    exp_t expq[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic bit mBusy(input int n);
        return (n >= acc_cyc) && (n <= acc_cyc + L - 1);
    endfunction

    function automatic bit mStall(input stim_t x, input int n);
        bit lu;
        lu = x.mem_read && (x.wr != 0) &&
             ((x.use_rs && x.rs == x.wr) || (x.use_rt && x.rt == x.wr));
        return lu || (mBusy(n) && (x.md_start || x.md_use));
    endfunction

    task automatic modelEdge(input stim_t x);
        if (!x.rst_n) begin
            acc_cyc = -1000;
            scnt    = 0;
        end else begin
            if (!x.br && mStall(x, cyc)) scnt = (scnt >= CMAX) ? CMAX : scnt + 1;
            if (x.md_start && !x.br && !mStall(x, cyc)) acc_cyc = cyc + 1;
        end
        cyc++;
    endtask

    function automatic exp_t expectOf(input stim_t x);
        exp_t e;
        e.cyc = cyc;
        e.cnt = CNT_W'(scnt);
        if (!x.rst_n)      e.ctl = 6'b0011_00;
        else begin
            if (x.br)                 e.ctl[5:2] = 4'b1111;
            else if (mStall(x, cyc))  e.ctl[5:2] = 4'b0001;
            else                      e.ctl[5:2] = 4'b1100;
            e.ctl[1] = mBusy(cyc);
            e.ctl[0] = (cyc == acc_cyc + L - 1);
        end
        return e;
    endfunction

    task automatic applyStimulus(input stim_t x);
        @(posedge clk);
        modelEdge(cur);
        #1;
        cur = x;
        expq.push_back(expectOf(x));
    endtask

    task automatic checkOutput(input exp_t e);
        logic [5:0] got;
        got = {pc_en, ifid_en, ifid_flush, idex_flush, md_busy, md_done};
        vectors++;
        if (got !== e.ctl || stall_cnt !== e.cnt) begin
            miscompares++;
            $display("[TB] FAIL cycle%0d pc/ifen/ifflush/idexflush/busy/done got %b want %b, stall_cnt got %0d want %0d",
                     e.cyc, got, e.ctl, stall_cnt, e.cnt);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        cur = IDLE;
        cur.rst_n = 1'b0;
        s = cur;
        repeat (2) applyStimulus(s);
        applyStimulus(IDLE);

        // load-use on rs, then the same pattern through $zero
        s = IDLE; s.mem_read = 1; s.wr = 5'd8; s.use_rs = 1; s.rs = 5'd8;
        applyStimulus(s);
        applyStimulus(IDLE);
        s.wr = 5'd0; s.rs = 5'd0;
        applyStimulus(s);
        s = IDLE; s.mem_read = 1; s.wr = 5'd9; s.use_rt = 1; s.rt = 5'd9; s.br = 1;
        applyStimulus(s);

        // mult/div accepted, then a dependent mfhi waiting in ID
        s = IDLE; s.md_start = 1;
        applyStimulus(s);
        s = IDLE; s.md_use = 1;
        repeat (L + 2) applyStimulus(s);

        // start discarded by a concurrent flush
        s = IDLE; s.md_start = 1; s.br = 1;
        applyStimulus(s);
        repeat (2) applyStimulus(IDLE);

        // reset in the middle of a countdown
        s = IDLE; s.md_start = 1;
        applyStimulus(s);
        s = IDLE; s.md_use = 1;
        repeat (2) applyStimulus(s);
        s.rst_n = 0;
        applyStimulus(s);
        repeat (2) applyStimulus(IDLE);

        // counter saturation
        s = IDLE; s.mem_read = 1; s.wr = 5'd3; s.use_rt = 1; s.rt = 5'd3;
        repeat (20) applyStimulus(s);
        s.rst_n = 0;
        applyStimulus(s);

        for (int i = 0; i < 600; i++) begin
            s.rst_n    = ($urandom_range(0, 99) >= 3);
            s.rs       = 5'($urandom_range(0, 3));
            s.rt       = 5'($urandom_range(0, 3));
            s.use_rs   = ($urandom_range(0, 1) == 1);
            s.use_rt   = ($urandom_range(0, 1) == 1);
            s.md_start = ($urandom_range(0, 99) < 15);
            s.md_use   = ($urandom_range(0, 99) < 20);
            s.mem_read = ($urandom_range(0, 99) < 40);
            s.wr       = 5'($urandom_range(0, 3));
            s.br       = ($urandom_range(0, 99) < 15);
            applyStimulus(s);
        end

        repeat (3) @(negedge clk);
        if (expq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain pending got %0d want 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
